// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: reserve in order, complete out of order, retire in order.
// Optional synchronous flush port is enabled by defining REORDER_BUFFER_FLUSH_EN.
module reorder_buffer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
`ifdef REORDER_BUFFER_FLUSH_EN
  input  logic                   flush,
`endif
  output logic                   full,
  output logic                   empty,
  input  logic                   reserve_enable,
  output logic [INDEX_WIDTH-1:0] reserve_index,
  input  logic                   write_enable,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [WIDTH-1:0]       write_data,
  output logic                   write_error,
  input  logic                   read_enable,
  output logic                   read_valid,
  output logic [WIDTH-1:0]       read_data,
  output logic                   read_error
);

  logic [INDEX_WIDTH:0]   head_q, head_d, tail_q, tail_d, used;
  logic [INDEX_WIDTH-1:0] head_idx, tail_idx, write_offset;
  logic [DEPTH-1:0]       completed_q, completed_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic                   flush_req, reserve_ok, write_ok, read_ok;
  logic                   write_error_q, read_error_q;

`ifdef REORDER_BUFFER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign head_idx = head_q[INDEX_WIDTH-1:0];
  assign tail_idx = tail_q[INDEX_WIDTH-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[INDEX_WIDTH] != tail_q[INDEX_WIDTH]);

  assign reserve_index = tail_idx;
  assign read_valid    = !empty && completed_q[head_idx];
  assign read_data     = mem_q[head_idx];
  assign write_error   = write_error_q;
  assign read_error    = read_error_q;

  // An index is reserved when its distance from head (mod DEPTH) is below the occupancy.
  assign used         = tail_q - head_q;
  assign write_offset = write_index - head_idx;

  assign reserve_ok = reserve_enable && !full && !flush_req;
  assign write_ok   = write_enable && !flush_req && ({1'b0, write_offset} < used) &&
                      !completed_q[write_index];
  assign read_ok    = read_enable && read_valid && !flush_req;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    completed_d = completed_q;
    if (flush_req) begin
      head_d      = '0;
      tail_d      = '0;
      completed_d = '0;
    end else begin
      if (write_ok) completed_d[write_index] = 1'b1;
      if (read_ok) begin
        completed_d[head_idx] = 1'b0;
        head_d                = head_q + 1'b1;
      end
      if (reserve_ok) begin
        completed_d[tail_idx] = 1'b0;
        tail_d                = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q        <= '0;
      tail_q        <= '0;
      completed_q   <= '0;
      write_error_q <= 1'b0;
      read_error_q  <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      completed_q   <= completed_d;
      write_error_q <= write_enable && !write_ok && !flush_req;
      read_error_q  <= read_enable && !read_valid && !flush_req;
    end
  end

  // Data contents are only observable through completed entries, so no reset is needed.
  always_ff @(posedge clock) begin
    if (write_ok) mem_q[write_index] <= write_data;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based model.
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          full, empty, read_valid, write_error, read_error;
  logic          reserve_enable = 1'b0, write_enable = 1'b0, read_enable = 1'b0;
  logic [IW-1:0] reserve_index, write_index = '0;
  logic [7:0]    write_data = '0, read_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  reorder_buffer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .resetn         (resetn),
`ifdef REORDER_BUFFER_FLUSH_EN
    .flush          (flush),
`endif
    .full           (full),
    .empty          (empty),
    .reserve_enable (reserve_enable),
    .reserve_index  (reserve_index),
    .write_enable   (write_enable),
    .write_index    (write_index),
    .write_data     (write_data),
    .write_error    (write_error),
    .read_enable    (read_enable),
    .read_valid     (read_valid),
    .read_data      (read_data),
    .read_error     (read_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of reserved indices plus per-index done flag and data.
  int       rob_q[$];
  bit       done[DEPTH];
  bit [7:0] mdata[DEPTH];
  int       next_tail;
  bit       exp_werr, exp_rerr;
  bit       m_inq, m_wok, m_rok, m_sok;

  always @(posedge clock or negedge resetn) begin
    if (!resetn || flush) begin
      rob_q.delete();
      next_tail = 0;
      for (int i = 0; i < DEPTH; i++) done[i] = 1'b0;
      exp_werr = 1'b0;
      exp_rerr = 1'b0;
    end else begin
      m_inq = 1'b0;
      foreach (rob_q[i]) if (rob_q[i] == int'(write_index)) m_inq = 1'b1;
      m_wok = write_enable && m_inq && !done[write_index];
      m_rok = read_enable && rob_q.size() != 0 && done[rob_q[0]];
      m_sok = reserve_enable && rob_q.size() < DEPTH;
      exp_werr = write_enable && !m_wok;
      exp_rerr = read_enable && !m_rok;
      if (m_wok) begin
        done[write_index]  = 1'b1;
        mdata[write_index] = write_data;
      end
      if (m_rok) begin
        done[rob_q[0]] = 1'b0;
        void'(rob_q.pop_front());
      end
      if (m_sok) begin
        rob_q.push_back(next_tail);
        done[next_tail] = 1'b0;
        next_tail = (next_tail + 1) % DEPTH;
      end
    end
  end

  always @(negedge clock) begin
    bit exp_rv;
    exp_rv = rob_q.size() != 0 && done[rob_q[0]];
    check("full", 32'(full), 32'(rob_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(rob_q.size() == 0));
    check("read_valid", 32'(read_valid), 32'(exp_rv));
    check("reserve_index", 32'(reserve_index), 32'(next_tail));
    check("write_error", 32'(write_error), 32'(exp_werr));
    check("read_error", 32'(read_error), 32'(exp_rerr));
    if (exp_rv) check("read_data", 32'(read_data), 32'(mdata[rob_q[0]]));
  end

  task automatic tick();
    @(posedge clock);
    #1;
    reserve_enable = 1'b0;
    write_enable   = 1'b0;
    read_enable    = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rv", 32'(read_valid), 32'd0);
    check("rst_ridx", 32'(reserve_index), 32'd0);
    check("rst_errs", {30'd0, write_error, read_error}, 32'd0);
    reserve_enable = 1'b0;
    write_enable   = 1'b0;
    read_enable    = 1'b0;
    flush          = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    write_enable = 1'b1;
    write_index  = IW'(idx);
    write_data   = d;
  endtask

  initial begin
    do_reset();

    // In-order retire of out-of-order completions.
    for (int i = 0; i < 3; i++) begin
      reserve_enable = 1'b1;
      check("t1_ridx", 32'(reserve_index), 32'(i));
      tick();
    end
    check("t1_notempty", 32'(empty), 32'd0);
    wr(2, 8'hC2); tick();
    check("t1_rv_a", 32'(read_valid), 32'd0);
    wr(1, 8'hB1); tick();
    check("t1_rv_b", 32'(read_valid), 32'd0);
    wr(0, 8'hA0); tick();
    check("t1_rv_c", 32'(read_valid), 32'd1);
    check("t1_d0", 32'(read_data), 32'hA0);
    read_enable = 1'b1; tick();
    check("t1_d1", 32'(read_data), 32'hB1);
    read_enable = 1'b1; tick();
    check("t1_d2", 32'(read_data), 32'hC2);
    read_enable = 1'b1; tick();
    check("t1_empty", 32'(empty), 32'd1);

    // Fill, overflow, wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      reserve_enable = 1'b1;
      tick();
    end
    check("t2_full", 32'(full), 32'd1);
    check("t2_ridx", 32'(reserve_index), 32'd0);
    reserve_enable = 1'b1; tick();
    check("t2_full9", 32'(full), 32'd1);
    check("t2_ridx9", 32'(reserve_index), 32'd0);
    wr(0, 8'h10); tick();
    check("t2_d", 32'(read_data), 32'h10);
    read_enable = 1'b1; tick();
    check("t2_notfull", 32'(full), 32'd0);
    reserve_enable = 1'b1;
    check("t2_wrapidx", 32'(reserve_index), 32'd0);
    tick();
    check("t2_refull", 32'(full), 32'd1);

    // Illegal writes.
    do_reset();
    wr(5, 8'h99); tick();
    check("t3_werr", 32'(write_error), 32'd1);
    check("t3_rv", 32'(read_valid), 32'd0);
    tick();
    check("t3_werr_pulse", 32'(write_error), 32'd0);
    reserve_enable = 1'b1; tick();
    wr(0, 8'h11); tick();
    check("t3_werr_ok", 32'(write_error), 32'd0);
    wr(0, 8'h22); tick();
    check("t3_werr_dup", 32'(write_error), 32'd1);
    check("t3_keep", 32'(read_data), 32'h11);

    // Illegal reads.
    do_reset();
    read_enable = 1'b1; tick();
    check("t4_rerr_empty", 32'(read_error), 32'd1);
    tick();
    check("t4_rerr_pulse", 32'(read_error), 32'd0);
    reserve_enable = 1'b1; tick();
    read_enable = 1'b1; tick();
    check("t4_rerr_pend", 32'(read_error), 32'd1);
    check("t4_head", 32'(empty), 32'd0);

    // Write head and read in the same cycle.
    wr(0, 8'h55);
    read_enable = 1'b1; tick();
    check("t5_rerr", 32'(read_error), 32'd1);
    check("t5_rv", 32'(read_valid), 32'd1);
    check("t5_d", 32'(read_data), 32'h55);

`ifdef REORDER_BUFFER_FLUSH_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      reserve_enable = 1'b1;
      tick();
    end
    wr(0, 8'h01); tick();
    wr(1, 8'h02); tick();
    flush = 1'b1;
    reserve_enable = 1'b1;
    tick();
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_ridx", 32'(reserve_index), 32'd0);
    check("t6_errs", {30'd0, write_error, read_error}, 32'd0);
`endif

    // Random traffic against the model, with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      reserve_enable = ($urandom % 3) != 0;
      read_enable    = ($urandom % 2) != 0;
      write_enable   = ($urandom % 4) != 0;
      write_data     = 8'($urandom);
      if (rob_q.size() != 0 && ($urandom % 4) != 0)
        write_index = IW'(rob_q[$urandom_range(0, rob_q.size() - 1)]);
      else
        write_index = IW'($urandom);
`ifdef REORDER_BUFFER_FLUSH_EN
      flush = ($urandom % 64) == 0;
`endif
      @(posedge clock);
      #1;
    end
    tick();
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
